cmd_frame_buf: RTL and testbench
================================

CMD_FRAME_BUF -- requirements
Module: cmd_frame_buf

Interface
REQ-001 SHALL have parameter PARAM_W, default 52: width of param output; legal range 52..64.
REQ-002 SHALL have parameter EN_WRITE, default 0: 1 enables decoding of Write (8'hC3); requires PARAM_W >= 58.
REQ-003 SHALL have ports: clk_cmd  in  1  command bit clock; rst_for_new_package  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: bits_in  in  1  serial data bit; bit_vld  in  1  bits_in qualifier; sync  in  1  preamble detected, frame open; frame_end  in  1  one-cycle end-of-frame pulse.
REQ-005 SHALL have outputs: cmd  out  8  decoded opcode; cmd_id  out  4  table index; param  out  PARAM_W  payload incl. CRC; param_len  out  7  expected payload bits.
REQ-006 SHALL have handshake and status: pkt_valid  out  1; pkt_ack  in  1; pkt_err  out  1; err_code  out  2; en_crc5  out  1; en_crc16  out  1.

Function
REQ-007 SHALL implement FSM states IDLE, OPC, PARAM, DONE, ERR.
REQ-008 IDLE: sync=1 and bit_vld=1 -> shift first opcode bit, go to OPC.
REQ-009 OPC: each valid bit shifts into the opcode register; at 2, 4 and 8 bits, compare against table entries of that length.
REQ-010 Opcode table (code/len -> param bits, CRC): 00/2 QueryRep 2 none; 01/2 ACK 16 none; 1000/4 Query 18 CRC5; 1001/4 QueryAdjust 5 none; 1010/4 Select 52 CRC16; C0/8 NAK 0 none; C1/8 Req_RN 32 CRC16; C2/8 Read 50 CRC16; C3/8 Write 58 CRC16 (only if EN_WRITE=1); C4/8 Kill 51 CRC16; C5/8 Lock 52 CRC16.
REQ-011 On match: cmd, cmd_id and param_len SHALL load in the same cycle; go to PARAM, or to DONE if length 0 (NAK).
REQ-012 After 8 opcode bits with no match (including C3 when EN_WRITE=0): go to ERR, err_code=1 (unknown opcode).
REQ-013 PARAM: each valid bit shifts in LSB-first into param; the first payload bit ends at param[param_len-1]; param bits above param_len read 0.
REQ-014 A counter SHALL count payload bits; when count reaches param_len, go to DONE on the cycle after the last bit.
REQ-015 DONE: pkt_valid=1; cmd, param and param_len SHALL be held stable until pkt_ack=1, then go to IDLE and clear pkt_valid the next cycle.
REQ-016 frame_end in OPC or PARAM before completion: go to ERR, err_code=2 (short).
REQ-017 bit_vld in DONE without pkt_ack: go to ERR, err_code=3 (long); pkt_valid drops.
REQ-018 pkt_ack and bit_vld in the same DONE cycle: pkt_ack wins; the bit is discarded.
REQ-019 frame_end in IDLE or DONE SHALL be ignored.
REQ-020 ERR: pkt_err=1, err_code held; the FSM leaves ERR only by reset.
REQ-021 bit_vld=0 cycles SHALL not advance the opcode register, counter or FSM.
REQ-022 en_crc5 and en_crc16 SHALL both be 1 until a match; after a match, en_crc5=1 only for CRC5 commands and en_crc16=1 only for CRC16 commands, held until reset.

Reset
REQ-023 Reset asserted SHALL immediately force: FSM=IDLE, cmd=8'h00, cmd_id=4'hF, param=0, param_len=0, counter=0, pkt_valid=0, pkt_err=0, err_code=0, en_crc5=1, en_crc16=1.
REQ-024 Reset mid-frame SHALL discard all partial data; no pkt_valid is produced for the aborted frame.

Structure
REQ-025 Package cmd_buf_pkg SHALL hold opcode constants, cmd_id enum, param-length table, CRC-type enum, err_code constants, and FSM state typedef.
REQ-026 Opcode comparison SHALL live in a combinational sub-module cmd_opc_match (inputs: opcode bits, bit count, EN_WRITE; outputs: hit, cmd_id, length, CRC type).

Verification
REQ-027 Query: bits 1000 plus 18 payload bits -> cmd=8'h38, param_len=18, en_crc5=1, en_crc16=0; pkt_valid 1 cycle after the last bit; held until pkt_ack.
REQ-028 NAK: bits 11000000 -> pkt_valid the cycle after the 8th bit, param=0, en_crc5=0, en_crc16=0.
REQ-029 Opcode 11000011 with EN_WRITE=0 -> pkt_err=1, err_code=1; with EN_WRITE=1, PARAM_W=58 and 58 payload bits -> pkt_valid=1, cmd=8'hC3.
REQ-030 Req_RN with frame_end after 20 of 32 payload bits -> err_code=2, pkt_valid never 1.
REQ-031 ACK complete, then 1 extra bit_vld before pkt_ack -> err_code=3, pkt_valid=0; repeat with the extra bit coincident with pkt_ack -> IDLE, no error.
REQ-032 Reset pulse at payload bit 30 of Read -> all outputs at reset values; a following QueryRep 00+2 bits decodes correctly.

Source files
------------

// File: rtl/cmd_buf_pkg.sv
// Shared types and tables for the serial command frame buffer: opcode values,
// command ids, payload lengths, CRC kinds, error codes and FSM states.
package cmd_buf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OPC,
    ST_PARAM,
    ST_DONE,
    ST_ERR
  } state_t;

  typedef enum logic [3:0] {
    ID_QUERYREP = 4'd0,
    ID_ACK      = 4'd1,
    ID_QUERY    = 4'd2,
    ID_QUERYADJ = 4'd3,
    ID_SELECT   = 4'd4,
    ID_NAK      = 4'd5,
    ID_REQ_RN   = 4'd6,
    ID_READ     = 4'd7,
    ID_WRITE    = 4'd8,
    ID_KILL     = 4'd9,
    ID_LOCK     = 4'd10,
    ID_NONE     = 4'hF
  } cmd_id_t;

  typedef enum logic [1:0] {
    CRC_NONE,
    CRC_5,
    CRC_16
  } crc_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_UNKNOWN = 2'd1;
  localparam logic [1:0] ERR_SHORT   = 2'd2;
  localparam logic [1:0] ERR_LONG    = 2'd3;

  // Short opcodes carry a tag in the upper bits so they never alias 8'h00;
  // the on-air code is always the low 2 or 4 bits.
  localparam logic [7:0] OPC_QUERYREP = 8'h10;
  localparam logic [7:0] OPC_ACK      = 8'h11;
  localparam logic [7:0] OPC_QUERY    = 8'h38;
  localparam logic [7:0] OPC_QUERYADJ = 8'h39;
  localparam logic [7:0] OPC_SELECT   = 8'h3A;
  localparam logic [7:0] OPC_NAK      = 8'hC0;
  localparam logic [7:0] OPC_REQ_RN   = 8'hC1;
  localparam logic [7:0] OPC_READ     = 8'hC2;
  localparam logic [7:0] OPC_WRITE    = 8'hC3;
  localparam logic [7:0] OPC_KILL     = 8'hC4;
  localparam logic [7:0] OPC_LOCK     = 8'hC5;

  function automatic logic [7:0] opc_of(input cmd_id_t id);
    logic [7:0] v;
    case (id)
      ID_QUERYREP: v = OPC_QUERYREP;
      ID_ACK:      v = OPC_ACK;
      ID_QUERY:    v = OPC_QUERY;
      ID_QUERYADJ: v = OPC_QUERYADJ;
      ID_SELECT:   v = OPC_SELECT;
      ID_NAK:      v = OPC_NAK;
      ID_REQ_RN:   v = OPC_REQ_RN;
      ID_READ:     v = OPC_READ;
      ID_WRITE:    v = OPC_WRITE;
      ID_KILL:     v = OPC_KILL;
      ID_LOCK:     v = OPC_LOCK;
      default:     v = 8'h00;
    endcase
    return v;
  endfunction

  function automatic logic [6:0] param_len_of(input cmd_id_t id);
    logic [6:0] v;
    case (id)
      ID_QUERYREP: v = 7'd2;
      ID_ACK:      v = 7'd16;
      ID_QUERY:    v = 7'd18;
      ID_QUERYADJ: v = 7'd5;
      ID_SELECT:   v = 7'd52;
      ID_NAK:      v = 7'd0;
      ID_REQ_RN:   v = 7'd32;
      ID_READ:     v = 7'd50;
      ID_WRITE:    v = 7'd58;
      ID_KILL:     v = 7'd51;
      ID_LOCK:     v = 7'd52;
      default:     v = 7'd0;
    endcase
    return v;
  endfunction

  function automatic crc_t crc_of(input cmd_id_t id);
    crc_t v;
    case (id)
      ID_QUERY:                               v = CRC_5;
      ID_SELECT, ID_REQ_RN, ID_READ,
      ID_WRITE, ID_KILL, ID_LOCK:             v = CRC_16;
      default:                                v = CRC_NONE;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/cmd_opc_match.sv
// Combinational opcode lookup: checks the partially received opcode against
// the table entries whose length equals the current bit count.
module cmd_opc_match
  import cmd_buf_pkg::*;
#(
  parameter bit EN_WRITE = 1'b0
) (
  input  logic [7:0] opcode,
  input  logic [3:0] bit_cnt,
  output logic       hit,
  output cmd_id_t    cmd_id,
  output logic [6:0] len,
  output crc_t       crc
);

  always_comb begin
    cmd_id = ID_NONE;
    case (bit_cnt)
      4'd2: begin
        if (opcode[1:0] == OPC_QUERYREP[1:0])  cmd_id = ID_QUERYREP;
        else if (opcode[1:0] == OPC_ACK[1:0])  cmd_id = ID_ACK;
      end
      4'd4: begin
        if (opcode[3:0] == OPC_QUERY[3:0])         cmd_id = ID_QUERY;
        else if (opcode[3:0] == OPC_QUERYADJ[3:0]) cmd_id = ID_QUERYADJ;
        else if (opcode[3:0] == OPC_SELECT[3:0])   cmd_id = ID_SELECT;
      end
      4'd8: begin
        if (opcode == OPC_NAK)                     cmd_id = ID_NAK;
        else if (opcode == OPC_REQ_RN)             cmd_id = ID_REQ_RN;
        else if (opcode == OPC_READ)               cmd_id = ID_READ;
        else if (opcode == OPC_WRITE && EN_WRITE)  cmd_id = ID_WRITE;
        else if (opcode == OPC_KILL)               cmd_id = ID_KILL;
        else if (opcode == OPC_LOCK)               cmd_id = ID_LOCK;
      end
      default: cmd_id = ID_NONE;
    endcase
    hit = (cmd_id != ID_NONE);
    len = param_len_of(cmd_id);
    crc = crc_of(cmd_id);
  end

endmodule

// File: rtl/cmd_frame_buf.sv
// Serial command frame buffer: assembles opcode and payload bits into a
// decoded packet, presents it with a valid/ack handshake and flags framing errors.
module cmd_frame_buf
  import cmd_buf_pkg::*;
#(
  parameter int PARAM_W  = 52,
  parameter int EN_WRITE = 0
) (
  input  logic               clk_cmd,
  input  logic               rst_for_new_package,
  input  logic               bits_in,
  input  logic               bit_vld,
  input  logic               sync,
  input  logic               frame_end,
  output logic [7:0]         cmd,
  output logic [3:0]         cmd_id,
  output logic [PARAM_W-1:0] param,
  output logic [6:0]         param_len,
  output logic               pkt_valid,
  input  logic               pkt_ack,
  output logic               pkt_err,
  output logic [1:0]         err_code,
  output logic               en_crc5,
  output logic               en_crc16
);

  // Write needs 58 payload bits; a narrower param bus cannot hold it.
  localparam bit WRITE_OK = (EN_WRITE != 0) && (PARAM_W >= 58);

  state_t     state, state_nxt;
  logic [6:0] opc;
  logic [3:0] opc_cnt;
  logic [6:0] cnt;
  logic [7:0] opc_nxt;
  logic [3:0] opc_cnt_nxt;
  logic [6:0] cnt_inc;
  logic       hit;
  cmd_id_t    hit_id;
  logic [6:0] hit_len;
  crc_t       hit_crc;
  logic       start_opc, shift_opc, load_cmd, shift_param, set_err;
  logic [1:0] err_nxt;

  assign opc_nxt     = {opc, bits_in};
  assign opc_cnt_nxt = opc_cnt + 4'd1;
  assign cnt_inc     = cnt + 7'd1;
  assign pkt_valid   = (state == ST_DONE);
  assign pkt_err     = (state == ST_ERR);

  cmd_opc_match #(
    .EN_WRITE(WRITE_OK)
  ) u_match (
    .opcode (opc_nxt),
    .bit_cnt(opc_cnt_nxt),
    .hit    (hit),
    .cmd_id (hit_id),
    .len    (hit_len),
    .crc    (hit_crc)
  );

  always_ff @(posedge clk_cmd or negedge rst_for_new_package) begin
    if (!rst_for_new_package) state <= ST_IDLE;
    else                      state <= state_nxt;
  end

  // A bit that completes the packet takes priority over a coincident frame_end.
  always_comb begin
    state_nxt   = state;
    start_opc   = 1'b0;
    shift_opc   = 1'b0;
    load_cmd    = 1'b0;
    shift_param = 1'b0;
    set_err     = 1'b0;
    err_nxt     = ERR_NONE;
    case (state)
      ST_IDLE: begin
        if (sync && bit_vld) begin
          start_opc = 1'b1;
          state_nxt = ST_OPC;
        end
      end
      ST_OPC: begin
        if (bit_vld) shift_opc = 1'b1;
        if (bit_vld && hit) begin
          load_cmd  = 1'b1;
          state_nxt = (hit_len == 7'd0) ? ST_DONE : ST_PARAM;
        end else if (bit_vld && opc_cnt_nxt == 4'd8) begin
          set_err   = 1'b1;
          err_nxt   = ERR_UNKNOWN;
          state_nxt = ST_ERR;
        end else if (frame_end) begin
          set_err   = 1'b1;
          err_nxt   = ERR_SHORT;
          state_nxt = ST_ERR;
        end
      end
      ST_PARAM: begin
        if (bit_vld) shift_param = 1'b1;
        if (bit_vld && cnt_inc == param_len) begin
          state_nxt = ST_DONE;
        end else if (frame_end) begin
          set_err   = 1'b1;
          err_nxt   = ERR_SHORT;
          state_nxt = ST_ERR;
        end
      end
      ST_DONE: begin
        if (pkt_ack) begin
          state_nxt = ST_IDLE;
        end else if (bit_vld) begin
          set_err   = 1'b1;
          err_nxt   = ERR_LONG;
          state_nxt = ST_ERR;
        end
      end
      ST_ERR:  state_nxt = ST_ERR;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Payload enters at bit 0 and walks up, so the first bit ends at param_len-1.
  always_ff @(posedge clk_cmd or negedge rst_for_new_package) begin
    if (!rst_for_new_package) begin
      opc       <= '0;
      opc_cnt   <= '0;
      cnt       <= '0;
      cmd       <= 8'h00;
      cmd_id    <= ID_NONE;
      param     <= '0;
      param_len <= '0;
      err_code  <= ERR_NONE;
      en_crc5   <= 1'b1;
      en_crc16  <= 1'b1;
    end else begin
      if (start_opc) begin
        opc     <= {6'd0, bits_in};
        opc_cnt <= 4'd1;
      end else if (shift_opc) begin
        opc     <= opc_nxt[6:0];
        opc_cnt <= opc_cnt_nxt;
      end
      if (load_cmd) begin
        cmd       <= opc_of(hit_id);
        cmd_id    <= hit_id;
        param_len <= hit_len;
        param     <= '0;
        cnt       <= '0;
        en_crc5   <= (hit_crc == CRC_5);
        en_crc16  <= (hit_crc == CRC_16);
      end else if (shift_param) begin
        param <= {param[PARAM_W-2:0], bits_in};
        cnt   <= cnt_inc;
      end
      if (set_err) err_code <= err_nxt;
    end
  end

endmodule

// File: tb/tb_cmd_frame_buf.sv
// Scoreboard bench: two instances (default build and Write-enabled, 58-bit param)
// share stimulus; expectations are queued per instance and checked by a monitor.
module tb_cmd_frame_buf;

  logic clk_cmd = 1'b0;
  logic rst_n;
  logic bits_in, bit_vld, sync, frame_end, pkt_ack;

  logic [7:0]  cmd0, cmd1;
  logic [3:0]  cmd_id0, cmd_id1;
  logic [51:0] param0;
  logic [57:0] param1;
  logic [6:0]  param_len0, param_len1;
  logic        pkt_valid0, pkt_valid1, pkt_err0, pkt_err1;
  logic [1:0]  err_code0, err_code1;
  logic        en_crc5_0, en_crc5_1, en_crc16_0, en_crc16_1;

  typedef struct {
    bit          is_err;
    logic [7:0]  cmd;
    logic [3:0]  id;
    logic [63:0] param;
    logic [6:0]  plen;
    logic        c5;
    logic        c16;
    logic [1:0]  ecode;
    int          cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc_n    = 0;
  int last_cyc = 0;

  logic        prev_v[2];
  logic        prev_e[2];
  logic [84:0] snap[2];
  logic        hold_bad[2];

  cmd_frame_buf dut0 (
    .clk_cmd(clk_cmd), .rst_for_new_package(rst_n),
    .bits_in(bits_in), .bit_vld(bit_vld), .sync(sync), .frame_end(frame_end),
    .cmd(cmd0), .cmd_id(cmd_id0), .param(param0), .param_len(param_len0),
    .pkt_valid(pkt_valid0), .pkt_ack(pkt_ack), .pkt_err(pkt_err0), .err_code(err_code0),
    .en_crc5(en_crc5_0), .en_crc16(en_crc16_0)
  );

  cmd_frame_buf #(.PARAM_W(58), .EN_WRITE(1)) dut1 (
    .clk_cmd(clk_cmd), .rst_for_new_package(rst_n),
    .bits_in(bits_in), .bit_vld(bit_vld), .sync(sync), .frame_end(frame_end),
    .cmd(cmd1), .cmd_id(cmd_id1), .param(param1), .param_len(param_len1),
    .pkt_valid(pkt_valid1), .pkt_ack(pkt_ack), .pkt_err(pkt_err1), .err_code(err_code1),
    .en_crc5(en_crc5_1), .en_crc16(en_crc16_1)
  );

  always #5 clk_cmd = ~clk_cmd;
  always @(posedge clk_cmd) cyc_n <= cyc_n + 1;

  function automatic void check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("[TB] FAIL %s: actual %h required %h", name, act, req);
  endfunction

  function automatic void fail_now(input string name);
    n_checks++;
    $display("[TB] FAIL %s: event seen, none expected", name);
  endfunction

  function automatic exp_t mk_pkt(input logic [7:0] c, input logic [3:0] id, input logic [63:0] p,
                                  input logic [6:0] pl, input logic c5, input logic c16);
    exp_t x;
    x.is_err = 1'b0; x.cmd = c; x.id = id; x.param = p; x.plen = pl;
    x.c5 = c5; x.c16 = c16; x.ecode = 2'd0; x.cyc = last_cyc + 1;
    return x;
  endfunction

  function automatic exp_t mk_err(input logic [1:0] code);
    exp_t x;
    x = mk_pkt(8'h00, 4'h0, 64'd0, 7'd0, 1'b0, 1'b0);
    x.is_err = 1'b1; x.ecode = code;
    return x;
  endfunction

  task automatic push_exp(input bit to0, input bit to1, input exp_t x);
    if (to0) q0.push_back(x);
    if (to1) q1.push_back(x);
  endtask

  task automatic pop_exp(input int idx, output exp_t x, output bit ok);
    ok = 1'b0;
    if (idx == 0 && q0.size() > 0) begin x = q0.pop_front(); ok = 1'b1; end
    if (idx == 1 && q1.size() > 0) begin x = q1.pop_front(); ok = 1'b1; end
  endtask

  task automatic check_output(input int idx, input logic v, input logic e, input logic [7:0] c,
                              input logic [3:0] id, input logic [63:0] p, input logic [6:0] pl,
                              input logic [1:0] ec, input logic c5, input logic c16);
    logic [84:0] act;
    exp_t x;
    bit ok;
    act = {c, id, p, pl, c5, c16};
    if (v && !prev_v[idx]) begin
      pop_exp(idx, x, ok);
      snap[idx] = act;
      hold_bad[idx] = 1'b0;
      if (!ok) fail_now($sformatf("dut%0d_unexpected_valid", idx));
      else if (x.is_err) fail_now($sformatf("dut%0d_valid_instead_of_err", idx));
      else begin
        check($sformatf("dut%0d_pkt", idx), act, {x.cmd, x.id, x.param, x.plen, x.c5, x.c16});
        check($sformatf("dut%0d_pkt_latency", idx), cyc_n, x.cyc);
      end
    end else if (v && act !== snap[idx]) begin
      hold_bad[idx] = 1'b1;
    end
    if (!v && prev_v[idx]) check($sformatf("dut%0d_pkt_hold", idx), hold_bad[idx], 1'b0);
    if (e && !prev_e[idx]) begin
      pop_exp(idx, x, ok);
      if (!ok) fail_now($sformatf("dut%0d_unexpected_err", idx));
      else if (!x.is_err) fail_now($sformatf("dut%0d_err_instead_of_pkt", idx));
      else begin
        check($sformatf("dut%0d_err_code", idx), {ec, v}, {x.ecode, 1'b0});
        check($sformatf("dut%0d_err_latency", idx), cyc_n, x.cyc);
      end
    end
    prev_v[idx] = v;
    prev_e[idx] = e;
  endtask

  always @(negedge clk_cmd) begin
    check_output(0, pkt_valid0, pkt_err0, cmd0, cmd_id0, {12'd0, param0}, param_len0,
                 err_code0, en_crc5_0, en_crc16_0);
    check_output(1, pkt_valid1, pkt_err1, cmd1, cmd_id1, {6'd0, param1}, param_len1,
                 err_code1, en_crc5_1, en_crc16_1);
  end

  task automatic drive(input logic b, input logic vld, input logic fe, input logic ack, input logic sy);
    @(negedge clk_cmd);
    bits_in = b; bit_vld = vld; frame_end = fe; pkt_ack = ack; sync = sy;
    last_cyc = cyc_n;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Sends the low n bits of v, most significant first; optional idle gaps.
  task automatic send_bits(input logic [63:0] v, input int n, input bit gap);
    for (int i = n - 1; i >= 0; i--) begin
      drive(v[i], 1'b1, 1'b0, 1'b0, 1'b1);
      if (gap && (i % 3 == 0) && i != 0) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
  endtask

  task automatic ack_pkt();
    idle(2);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);
  endtask

  task automatic check_reset();
    check("dut0_reset", {cmd0, cmd_id0, param_len0, pkt_valid0, pkt_err0, err_code0, en_crc5_0, en_crc16_0},
          {8'h00, 4'hF, 7'd0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1});
    check("dut0_reset_param", {76'd0, param0}, 128'd0);
    check("dut1_reset", {cmd1, cmd_id1, param_len1, pkt_valid1, pkt_err1, err_code1, en_crc5_1, en_crc16_1},
          {8'h00, 4'hF, 7'd0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1});
    check("dut1_reset_param", {70'd0, param1}, 128'd0);
  endtask

  task automatic apply_reset();
    @(negedge clk_cmd);
    bits_in = 1'b0; bit_vld = 1'b0; frame_end = 1'b0; pkt_ack = 1'b0; sync = 1'b0;
    rst_n = 1'b0;
    #1 check_reset();
    @(negedge clk_cmd);
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic apply_stimulus();
    // Query with idle gaps between payload bits
    send_bits(64'b1000, 4, 1'b0);
    send_bits(64'h2D5A3, 18, 1'b1);
    push_exp(1, 1, mk_pkt(8'h38, 4'd2, 64'h2D5A3, 7'd18, 1'b1, 1'b0));
    idle(2);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    ack_pkt();

    send_bits(64'hC0, 8, 1'b0);
    push_exp(1, 1, mk_pkt(8'hC0, 4'd5, 64'd0, 7'd0, 1'b0, 1'b0));
    ack_pkt();

    send_bits(64'b1001, 4, 1'b0);
    send_bits(64'b10110, 5, 1'b0);
    push_exp(1, 1, mk_pkt(8'h39, 4'd3, 64'h16, 7'd5, 1'b0, 1'b0));
    ack_pkt();

    send_bits(64'b1010, 4, 1'b0);
    send_bits(64'hA_5C3F_0E1D_2B47, 52, 1'b0);
    push_exp(1, 1, mk_pkt(8'h3A, 4'd4, 64'hA_5C3F_0E1D_2B47, 7'd52, 1'b0, 1'b1));
    ack_pkt();

    // Write: unknown without EN_WRITE, full packet on the Write-enabled build
    send_bits(64'hC3, 8, 1'b0);
    push_exp(1, 0, mk_err(2'd1));
    send_bits(64'h2AB_CDEF_0123_4567, 58, 1'b0);
    push_exp(0, 1, mk_pkt(8'hC3, 4'd8, 64'h2AB_CDEF_0123_4567, 7'd58, 1'b0, 1'b1));
    ack_pkt();
    apply_reset();

    // Req_RN cut short after 20 of 32 payload bits
    send_bits(64'hC1, 8, 1'b0);
    send_bits(64'hDEADB, 20, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    push_exp(1, 1, mk_err(2'd2));
    idle(3);
    apply_reset();

    // ACK followed by a stray bit before acknowledge
    send_bits(64'b01, 2, 1'b0);
    send_bits(64'hBEEF, 16, 1'b0);
    push_exp(1, 1, mk_pkt(8'h11, 4'd1, 64'hBEEF, 7'd16, 1'b0, 1'b0));
    idle(1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    push_exp(1, 1, mk_err(2'd3));
    idle(3);
    apply_reset();

    // ACK with the stray bit coincident with acknowledge, then Kill
    send_bits(64'b01, 2, 1'b0);
    send_bits(64'h1234, 16, 1'b0);
    push_exp(1, 1, mk_pkt(8'h11, 4'd1, 64'h1234, 7'd16, 1'b0, 1'b0));
    idle(1);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(2);
    send_bits(64'hC4, 8, 1'b0);
    send_bits(64'h5_1234_5678_9ABC, 51, 1'b0);
    push_exp(1, 1, mk_pkt(8'hC4, 4'd9, 64'h5_1234_5678_9ABC, 7'd51, 1'b0, 1'b1));
    ack_pkt();

    // Read aborted by reset at payload bit 30, then QueryRep
    send_bits(64'hC2, 8, 1'b0);
    send_bits(64'h0ABC_DEF1, 29, 1'b0);
    apply_reset();
    send_bits(64'b00, 2, 1'b0);
    send_bits(64'b10, 2, 1'b0);
    push_exp(1, 1, mk_pkt(8'h10, 4'd0, 64'h2, 7'd2, 1'b0, 1'b0));
    ack_pkt();

    send_bits(64'hC5, 8, 1'b0);
    send_bits(64'hF_EDCB_A987_6543, 52, 1'b0);
    push_exp(1, 1, mk_pkt(8'hC5, 4'd10, 64'hF_EDCB_A987_6543, 7'd52, 1'b0, 1'b1));
    ack_pkt();

    // 1011xxxx is no 4-bit command, so it fails only at the 8th bit
    send_bits(64'hB0, 8, 1'b0);
    push_exp(1, 1, mk_err(2'd1));
    idle(3);
    apply_reset();
  endtask

  initial begin
    prev_v[0] = 1'b0; prev_v[1] = 1'b0; prev_e[0] = 1'b0; prev_e[1] = 1'b0;
    hold_bad[0] = 1'b0; hold_bad[1] = 1'b0; snap[0] = '0; snap[1] = '0;
    bits_in = 1'b0; bit_vld = 1'b0; sync = 1'b0; frame_end = 1'b0; pkt_ack = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_reset();
    apply_reset();
    apply_stimulus();
    idle(4);
    check("dut0_queue_drained", q0.size(), 0);
    check("dut1_queue_drained", q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
